// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 pseudo-random generation / XOR stage.
//   prga_state_e : one-cycle-per-state FSM encoding used by fsm_prga_decrypt
//   MSG_LEN_DEF  : default number of message bytes
//   CHAR_LO/HI   : inclusive bounds of the accepted lowercase range ('a'..'z')
//   CHAR_SP      : space, the only other accepted plaintext byte
// ---------------------------------------------------------------------------
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_I_INC   = 4'd1,
        ST_SI_ADDR = 4'd2,
        ST_SI_WAIT = 4'd3,
        ST_SI_READ = 4'd4,
        ST_SJ_ADDR = 4'd5,
        ST_SJ_WAIT = 4'd6,
        ST_SJ_READ = 4'd7,
        ST_WR_SI   = 4'd8,
        ST_WR_SJ   = 4'd9,
        ST_F_ADDR  = 4'd10,
        ST_F_WAIT  = 4'd11,
        ST_F_READ  = 4'd12,
        ST_D_WRITE = 4'd13,
        ST_DONE    = 4'd14
    } prga_state_e;

endpackage

// File: rtl/prga_char_check.sv
// ---------------------------------------------------------------------------
// prga_char_check
// Combinational classifier for one plaintext byte.
//   byte_i     : candidate plaintext byte
//   in_range_o : 1 when byte_i is 'a'..'z' or space
// ---------------------------------------------------------------------------
module prga_char_check
    import rc4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] byte_i,
    output logic              in_range_o
);

    logic is_lower;
    logic is_space;

    assign is_lower   = (byte_i >= DATA_W'(CHAR_LO)) && (byte_i <= DATA_W'(CHAR_HI));
    assign is_space   = (byte_i == DATA_W'(CHAR_SP));
    assign in_range_o = is_lower || is_space;

endmodule

// File: rtl/fsm_prga_decrypt.sv
// ---------------------------------------------------------------------------
// fsm_prga_decrypt
// RC4 PRGA + XOR stage. Once s_memory holds the keyed permutation, walks
// MSG_LEN ciphertext bytes, keeps permuting S and writes the plaintext out.
// msg_valid reports whether every plaintext byte was 'a'..'z' or space.
//   clk, reset       : clock, synchronous active-low reset
//   start / finish   : level handshake with the controller
//   s_addr/s_wr_data/s_wren/s_q : s_memory port (read latency 1 or 2)
//   m_addr/m_q       : encrypted_message ROM port
//   d_addr/d_wr_data/d_wren     : decrypted_message RAM write port
//   msg_valid        : plaintext character check, meaningful while finish=1
// Every byte takes 13 cycles; every memory read holds its address for the
// ADDR, WAIT and READ states and captures data at the end of READ.
// ---------------------------------------------------------------------------
module fsm_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int DATA_W  = 8,
    localparam int K_W    = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wr_data,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_q,
    output logic [K_W-1:0]    m_addr,
    input  logic [DATA_W-1:0] m_q,
    output logic [K_W-1:0]    d_addr,
    output logic [DATA_W-1:0] d_wr_data,
    output logic              d_wren,
    output logic              msg_valid
);

    prga_state_e       state_q, state_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] j_q, j_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [DATA_W-1:0] sj_q, sj_d;
    logic [DATA_W-1:0] f_q, f_d;
    logic [DATA_W-1:0] mb_q, mb_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] plain;
    logic              plain_ok;
    logic [DATA_W-1:0] f_index;

    assign plain   = f_q ^ mb_q;
    // After the swap S[i]=sj and S[j]=si, so S[i]+S[j] is simply si+sj.
    assign f_index = si_q + sj_q;

    prga_char_check #(
        .DATA_W (DATA_W)
    ) u_char_check (
        .byte_i     (plain),
        .in_range_o (plain_ok)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            mb_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            mb_q    <= mb_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        mb_d      = mb_q;
        valid_d   = valid_q;
        finish    = 1'b0;
        s_addr    = '0;
        s_wr_data = '0;
        s_wren    = 1'b0;
        m_addr    = '0;
        d_addr    = '0;
        d_wr_data = '0;
        d_wren    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b1;
                    state_d = ST_I_INC;
                end
            end
            ST_I_INC: begin
                i_d     = i_q + 1'b1;
                state_d = ST_SI_ADDR;
            end
            ST_SI_ADDR: begin
                s_addr  = i_q;
                state_d = ST_SI_WAIT;
            end
            ST_SI_WAIT: begin
                s_addr  = i_q;
                state_d = ST_SI_READ;
            end
            ST_SI_READ: begin
                s_addr  = i_q;
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = ST_SJ_ADDR;
            end
            ST_SJ_ADDR: begin
                s_addr  = j_q;
                state_d = ST_SJ_WAIT;
            end
            ST_SJ_WAIT: begin
                s_addr  = j_q;
                state_d = ST_SJ_READ;
            end
            ST_SJ_READ: begin
                s_addr  = j_q;
                sj_d    = s_q;
                state_d = ST_WR_SI;
            end
            // When i==j both writes store the same value, leaving S intact.
            ST_WR_SI: begin
                s_addr    = i_q;
                s_wr_data = sj_q;
                s_wren    = 1'b1;
                state_d   = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                s_addr    = j_q;
                s_wr_data = si_q;
                s_wren    = 1'b1;
                state_d   = ST_F_ADDR;
            end
            ST_F_ADDR: begin
                s_addr  = f_index;
                m_addr  = k_q;
                state_d = ST_F_WAIT;
            end
            ST_F_WAIT: begin
                s_addr  = f_index;
                m_addr  = k_q;
                state_d = ST_F_READ;
            end
            ST_F_READ: begin
                s_addr  = f_index;
                m_addr  = k_q;
                f_d     = s_q;
                mb_d    = m_q;
                state_d = ST_D_WRITE;
            end
            // The character check never cuts the run short: all bytes are written.
            ST_D_WRITE: begin
                d_addr    = k_q;
                d_wr_data = plain;
                d_wren    = 1'b1;
                valid_d   = valid_q & plain_ok;
                if (k_q == K_W'(MSG_LEN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_I_INC;
                end
            end
            ST_DONE: begin
                finish = 1'b1;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign msg_valid = valid_q;

endmodule
